des_lane_arbiter: RTL

- Shares one deserializing datapath between NUM_SRC serial requesters.
- Arbitrates round-robin and grants one source for a full frame of BEATS input beats.
- Assembles the beats into one WIDTH_OUTPUT word and presents it with the source ID on a valid/ready output.
- Sits between per-lane serial links and the downstream word consumer.

---
 rtl/des_lane_arbiter_if.sv | 34 +++
 rtl/des_lane_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/des_lane_arbiter_if.sv
// Bus between the serial lanes, the lane arbiter and the downstream word consumer.
//   I_Req   : per-source beat valid
//   I_Data  : per-source beats, source i at [i*WIDTH_INPUT +: WIDTH_INPUT]
//   O_Grant : one-hot grant of the source being gathered
//   O_Valid : assembled word valid
//   O_Src   : source ID of the word
//   O_Data  : assembled word, zero while O_Valid is low
//   I_Ready : downstream accepts the word
// master = arbiter side, slave = lanes/consumer side.
interface des_lane_arbiter_if #(
  parameter int unsigned NUM_SRC      = 4,
  parameter int unsigned WIDTH_INPUT  = 8,
  parameter int unsigned WIDTH_OUTPUT = 32
);
  localparam int unsigned WIDTH_SRC = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0]             I_Req;
  logic [NUM_SRC*WIDTH_INPUT-1:0] I_Data;
  logic [NUM_SRC-1:0]             O_Grant;
  logic                           O_Valid;
  logic [WIDTH_SRC-1:0]           O_Src;
  logic [WIDTH_OUTPUT-1:0]        O_Data;
  logic                           I_Ready;

  modport master (
    input  I_Req, I_Data, I_Ready,
    output O_Grant, O_Valid, O_Src, O_Data
  );

  modport slave (
    output I_Req, I_Data, I_Ready,
    input  O_Grant, O_Valid, O_Src, O_Data
  );
endinterface

// File: rtl/des_lane_arbiter.sv
// Round-robin arbiter that shares one deserializer between NUM_SRC serial lanes.
// A winning lane is granted for BEATS beats; the beats are packed LSB-first
// into one WIDTH_OUTPUT word presented with the source ID on a valid/ready port.
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : des_lane_arbiter_if.master (I_Req, I_Data, I_Ready in; O_Grant, O_Valid, O_Src, O_Data out)
module des_lane_arbiter #(
  parameter int unsigned NUM_SRC      = 4,
  parameter int unsigned WIDTH_INPUT  = 8,
  parameter int unsigned WIDTH_OUTPUT = 32
) (
  input logic                clock,
  input logic                reset,
  des_lane_arbiter_if.master bus
);
  localparam int unsigned BEATS     = WIDTH_OUTPUT / WIDTH_INPUT;
  localparam int unsigned WIDTH_SRC = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned WIDTH_CNT = $clog2(BEATS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GATHER,
    S_OUTPUT
  } state_t;

  state_t                  state_q, state_d;
  logic [WIDTH_SRC-1:0]    src_q, src_d;
  logic [WIDTH_SRC-1:0]    last_q, last_d;
  logic [WIDTH_CNT-1:0]    count_q, count_d;
  logic [WIDTH_OUTPUT-1:0] data_q, data_d;
  logic [NUM_SRC-1:0]      grant_q, grant_d;
  logic                    valid_q, valid_d;
  logic [WIDTH_SRC-1:0]    osrc_q, osrc_d;
  logic [WIDTH_OUTPUT-1:0] odata_q, odata_d;

  logic                    any_req_c;
  logic [WIDTH_SRC-1:0]    winner_c;
  logic                    src_req_c;
  logic [WIDTH_INPUT-1:0]  beat_c;
  logic [WIDTH_OUTPUT-1:0] word_c;

  // Round-robin pick: lowest requester above last, otherwise lowest requester overall.
  always_comb begin
    any_req_c = 1'b0;
    winner_c  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!any_req_c && bus.I_Req[i] && (WIDTH_SRC'(i) > last_q)) begin
        any_req_c = 1'b1;
        winner_c  = WIDTH_SRC'(i);
      end
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!any_req_c && bus.I_Req[i]) begin
        any_req_c = 1'b1;
        winner_c  = WIDTH_SRC'(i);
      end
    end
  end

  // Beat and request of the granted source only; other lanes are ignored.
  always_comb begin
    src_req_c = 1'b0;
    beat_c    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_q == WIDTH_SRC'(i)) begin
        src_req_c = bus.I_Req[i];
        beat_c    = bus.I_Data[i*WIDTH_INPUT +: WIDTH_INPUT];
      end
    end
  end

  // Partial word with the current beat placed at the slot selected by count.
  always_comb begin
    word_c = data_q;
    for (int b = 0; b < BEATS; b++) begin
      if (count_q == WIDTH_CNT'(b)) begin
        word_c[b*WIDTH_INPUT +: WIDTH_INPUT] = beat_c;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    last_d  = last_q;
    count_d = count_q;
    data_d  = data_q;
    grant_d = '0;
    valid_d = valid_q;
    osrc_d  = osrc_q;
    odata_d = odata_q;

    case (state_q)
      S_IDLE: begin
        if (any_req_c) begin
          src_d   = winner_c;
          count_d = '0;
          data_d  = '0;
          grant_d = NUM_SRC'(1) << winner_c;
          state_d = S_GATHER;
        end
      end

      S_GATHER: begin
        grant_d = NUM_SRC'(1) << src_q;
        if (src_req_c) begin
          data_d = word_c;
          if (count_q == WIDTH_CNT'(BEATS - 1)) begin
            // Last beat: count wraps to 0 so it never stores BEATS.
            count_d = '0;
            grant_d = '0;
            valid_d = 1'b1;
            osrc_d  = src_q;
            odata_d = word_c;
            state_d = S_OUTPUT;
          end else begin
            count_d = count_q + WIDTH_CNT'(1);
          end
        end
      end

      S_OUTPUT: begin
        if (bus.I_Ready) begin
          last_d  = src_q;
          valid_d = 1'b0;
          osrc_d  = '0;
          odata_d = '0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      last_q  <= WIDTH_SRC'(NUM_SRC - 1);
      count_q <= '0;
      data_q  <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      osrc_q  <= '0;
      odata_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      last_q  <= last_d;
      count_q <= count_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      osrc_q  <= osrc_d;
      odata_q <= odata_d;
    end
  end

  assign bus.O_Grant = grant_q;
  assign bus.O_Valid = valid_q;
  assign bus.O_Src   = osrc_q;
  assign bus.O_Data  = odata_q;
endmodule
